sim_mem_req_adapter: RTL and testbench

//   Upstream request stage for the dual-port byte-masked sim memory: converts a valid/ready

---
 rtl/sim_mem_pkg.sv | 17 +
 rtl/sim_rsp_fifo.sv | 85 ++++++++
 rtl/sim_mem_req_adapter.sv | 174 +++++++++++++++++
 tb/tb_sim_mem_req_adapter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_mem_pkg.sv
// ----------------------------------------------------------------------------
// Package: sim_mem_pkg
// Purpose: Shared types and constants for the sim memory request adapter.
//          CNT_W sets the width of the optional statistics counters, and
//          sim_mem_stats_t groups those counters into one register.
// ----------------------------------------------------------------------------
package sim_mem_pkg;

   localparam int CNT_W = 32;

   typedef struct packed {
      logic [CNT_W-1:0] rd;
      logic [CNT_W-1:0] wr;
      logic [CNT_W-1:0] stall;
   } sim_mem_stats_t;

endpackage

// File: rtl/sim_rsp_fifo.sv
// ----------------------------------------------------------------------------
// Module: sim_rsp_fifo
// Purpose: First-word-fall-through FIFO for read responses. The head entry is
//          always visible on data_o while empty_o is low. Push and pop may
//          happen in the same cycle even when the FIFO is full, because the
//          pop frees the slot that the push fills. Pointers wrap with explicit
//          compares, so depths that are not a power of 2 also work.
// Ports:
//   clk_i    in   clock
//   rst_ni   in   asynchronous active-low reset
//   push_i   in   write data_i into the tail
//   data_i   in   push data
//   pop_i    in   drop the head entry (ignored when empty)
//   full_o   out  all DEPTH entries occupied
//   empty_o  out  no entries occupied
//   data_o   out  head entry
// ----------------------------------------------------------------------------
module sim_rsp_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] data_o
);

   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int FILL_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [FILL_W-1:0] FULL_CNT = FILL_W'(DEPTH);

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [PTR_W-1:0]  wrPtr_q;
   logic [PTR_W-1:0]  rdPtr_q;
   logic [FILL_W-1:0] fill_q;
   logic              popEn;
   logic              pushEn;

   assign full_o  = (fill_q == FULL_CNT);
   assign empty_o = (fill_q == '0);
   assign data_o  = mem_q[rdPtr_q];

   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign popEn  = pop_i & ~empty_o;
   assign pushEn = push_i & (~full_o | popEn);

   // Storage is cleared on reset so the head output reads zero until the first push.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         fill_q  <= '0;
      end else begin
         if (pushEn) begin
            mem_q[wrPtr_q] <= data_i;
            wrPtr_q        <= (wrPtr_q == LAST_PTR) ? '0 : wrPtr_q + PTR_W'(1);
         end
         if (popEn) begin
            rdPtr_q <= (rdPtr_q == LAST_PTR) ? '0 : rdPtr_q + PTR_W'(1);
         end
         case ({pushEn, popEn})
            2'b10:   fill_q <= fill_q + FILL_W'(1);
            2'b01:   fill_q <= fill_q - FILL_W'(1);
            default: fill_q <= fill_q;
         endcase
      end
   end

   // Upstream credits make an unpaired push into a full FIFO impossible; flag it if it ever happens.
   always @(posedge clk_i) begin
      if (rst_ni) begin
         assert (!(push_i && full_o && !popEn))
            else $error("sim_rsp_fifo: push to full FIFO without pop, response lost");
      end
   end

endmodule

// File: rtl/sim_mem_req_adapter.sv
// ----------------------------------------------------------------------------
// Module: sim_mem_req_adapter
// Purpose: Request stage for one port of the byte-masked sim memory. Turns a
//          valid/ready request stream (read or strobed write) into the memory
//          En/Wr/Addr/DataIn controls, follows each read through the fixed
//          DELAY read latency and returns the data on a valid/ready response
//          stream. A credit counter bounds outstanding reads (in flight plus
//          buffered) to RSP_DEPTH so read data is never dropped.
// Configuration:
//   SIM_MEM_ADAPTER_STATS_EN  when defined, adds rdCnt_o / wrCnt_o / stallCnt_o
//                             (read fires, write fires, stalled request cycles).
// Ports:
//   clk_i         in   clock (memory port shares it)
//   rst_ni        in   asynchronous active-low reset
//   reqValid_i    in   request valid
//   reqReady_o    out  request ready (credit available; registered state only)
//   reqWrite_i    in   1 = write, 0 = read
//   reqAddr_i     in   word address
//   reqData_i     in   write data
//   reqStrb_i     in   byte write strobes (ignored for reads)
//   rspValid_o    out  read response valid
//   rspReady_i    in   read response ready
//   rspData_o     out  read data
//   memEn_o       out  memory port enable
//   memWr_o       out  memory port byte write mask
//   memAddr_o     out  memory port address
//   memDataIn_o   out  memory port write data
//   memDataOut_i  in   memory port read data
//   rdCnt_o, wrCnt_o, stallCnt_o  out  statistics (only with the macro)
// ----------------------------------------------------------------------------
module sim_mem_req_adapter
   import sim_mem_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int LENGTH    = 32,
   parameter int DELAY     = 1,
   parameter int RSP_DEPTH = 2,
   localparam int STRB_W   = (WIDTH + 7) / 8,
   localparam int ADDR_W   = $clog2(LENGTH)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              reqValid_i,
   output logic              reqReady_o,
   input  logic              reqWrite_i,
   input  logic [ADDR_W-1:0] reqAddr_i,
   input  logic [WIDTH-1:0]  reqData_i,
   input  logic [STRB_W-1:0] reqStrb_i,
   output logic              rspValid_o,
   input  logic              rspReady_i,
   output logic [WIDTH-1:0]  rspData_o,
   output logic              memEn_o,
   output logic [STRB_W-1:0] memWr_o,
   output logic [ADDR_W-1:0] memAddr_o,
   output logic [WIDTH-1:0]  memDataIn_o,
   input  logic [WIDTH-1:0]  memDataOut_i
`ifdef SIM_MEM_ADAPTER_STATS_EN
   ,
   output logic [CNT_W-1:0]  rdCnt_o,
   output logic [CNT_W-1:0]  wrCnt_o,
   output logic [CNT_W-1:0]  stallCnt_o
`endif
);

   localparam int CRED_W = $clog2(RSP_DEPTH + 1);
   localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(RSP_DEPTH);

   if (DELAY < 1) begin : gDelayCheck
      $error("sim_mem_req_adapter: DELAY must be at least 1");
   end
   if (RSP_DEPTH < 1) begin : gDepthCheck
      $error("sim_mem_req_adapter: RSP_DEPTH must be at least 1");
   end

   logic              fire;
   logic              readFire;
   logic              writeFire;
   logic              rspPop;
   logic              rspEmpty;
   logic              rspFull;
   logic [CRED_W-1:0] credit_q;
   logic [CRED_W-1:0] credit_d;
   logic [DELAY-1:0]  vldPipe_q;
   logic [DELAY-1:0]  vldPipe_d;

   assign reqReady_o = (credit_q != '0);
   assign fire       = reqValid_i & reqReady_o;
   assign readFire   = fire & ~reqWrite_i;
   assign writeFire  = fire & reqWrite_i;
   assign rspPop     = rspValid_o & rspReady_i;

   assign memEn_o     = fire;
   assign memWr_o     = writeFire ? reqStrb_i : '0;
   assign memAddr_o   = reqAddr_i;
   assign memDataIn_o = reqData_i;

   // One credit per outstanding read; a read fire and a pop in the same cycle cancel out.
   always_comb begin
      credit_d = credit_q;
      if (readFire && !rspPop) begin
         credit_d = credit_q - CRED_W'(1);
      end else if (!readFire && rspPop) begin
         credit_d = credit_q + CRED_W'(1);
      end
   end

   // Bit k set means a read fired k+1 edges ago; the top bit marks the edge where memory data is valid.
   assign vldPipe_d = (vldPipe_q << 1) | DELAY'(readFire);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         credit_q  <= CRED_MAX;
         vldPipe_q <= '0;
      end else begin
         credit_q  <= credit_d;
         vldPipe_q <= vldPipe_d;
      end
   end

   sim_rsp_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (RSP_DEPTH)
   ) uRspFifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (vldPipe_q[DELAY-1]),
      .data_i  (memDataOut_i),
      .pop_i   (rspPop),
      .full_o  (rspFull),
      .empty_o (rspEmpty),
      .data_o  (rspData_o)
   );

   assign rspValid_o = ~rspEmpty;

   // A full response buffer means every credit is held by a buffered word.
   always @(posedge clk_i) begin
      if (rst_ni) begin
         assert (!(rspFull && credit_q != '0))
            else $error("sim_mem_req_adapter: response FIFO full while credits remain");
      end
   end

`ifdef SIM_MEM_ADAPTER_STATS_EN
   sim_mem_stats_t stats_q;
   sim_mem_stats_t stats_d;

   always_comb begin
      stats_d = stats_q;
      if (readFire) begin
         stats_d.rd = stats_q.rd + CNT_W'(1);
      end
      if (writeFire) begin
         stats_d.wr = stats_q.wr + CNT_W'(1);
      end
      if (reqValid_i && !reqReady_o) begin
         stats_d.stall = stats_q.stall + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stats_q <= '0;
      end else begin
         stats_q <= stats_d;
      end
   end

   assign rdCnt_o    = stats_q.rd;
   assign wrCnt_o    = stats_q.wr;
   assign stallCnt_o = stats_q.stall;
`endif

endmodule

// File: tb/tb_sim_mem_req_adapter.sv
// ----------------------------------------------------------------------------
// Testbench: tb_sim_mem_req_adapter
// Purpose: Directed checks of the request adapter driving a small byte-masked
//          memory model with a two-cycle read latency (DELAY=2, RSP_DEPTH=3,
//          WIDTH=16). Inputs change 1 ns after the rising edge and outputs
//          are sampled on the falling edge. Define SIM_MEM_ADAPTER_STATS_EN
//          to also check the statistics counters.
// ----------------------------------------------------------------------------
module tb_sim_mem_req_adapter;

   localparam int WIDTH     = 16;
   localparam int LENGTH    = 32;
   localparam int DELAY     = 2;
   localparam int RSP_DEPTH = 3;

   logic        clk;
   logic        rstN;
   logic        reqValid;
   logic        reqReady;
   logic        reqWrite;
   logic [4:0]  reqAddr;
   logic [15:0] reqData;
   logic [1:0]  reqStrb;
   logic        rspValid;
   logic        rspReady;
   logic [15:0] rspData;
   logic        memEn;
   logic [1:0]  memWr;
   logic [4:0]  memAddr;
   logic [15:0] memDataIn;
   logic [15:0] memDataOut;
`ifdef SIM_MEM_ADAPTER_STATS_EN
   logic [31:0] rdCnt;
   logic [31:0] wrCnt;
   logic [31:0] stallCnt;
`endif

   int checks   = 0;
   int failures = 0;

   sim_mem_req_adapter #(
      .WIDTH     (WIDTH),
      .LENGTH    (LENGTH),
      .DELAY     (DELAY),
      .RSP_DEPTH (RSP_DEPTH)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rstN),
      .reqValid_i   (reqValid),
      .reqReady_o   (reqReady),
      .reqWrite_i   (reqWrite),
      .reqAddr_i    (reqAddr),
      .reqData_i    (reqData),
      .reqStrb_i    (reqStrb),
      .rspValid_o   (rspValid),
      .rspReady_i   (rspReady),
      .rspData_o    (rspData),
      .memEn_o      (memEn),
      .memWr_o      (memWr),
      .memAddr_o    (memAddr),
      .memDataIn_o  (memDataIn),
      .memDataOut_i (memDataOut)
`ifdef SIM_MEM_ADAPTER_STATS_EN
      ,
      .rdCnt_o      (rdCnt),
      .wrCnt_o      (wrCnt),
      .stallCnt_o   (stallCnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte-masked memory port with two registered read stages: data read at edge N is captured by the adapter at edge N+2.
   logic [15:0] memArray [LENGTH];
   logic [15:0] rdStage1;
   logic [15:0] rdStage2;

   always @(posedge clk) begin
      if (memEn) begin
         for (int b = 0; b < 2; b++) begin
            if (memWr[b]) begin
               memArray[memAddr][8*b +: 8] <= memDataIn[8*b +: 8];
            end
         end
      end
      rdStage1 <= memArray[memAddr];
      rdStage2 <= rdStage1;
   end

   assign memDataOut = rdStage2;

   // Runaway guard in case some wait logic misbehaves.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
         else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
         end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request and hold it until it fires (bounded).
   task automatic applyStimulus(input logic wr, input logic [4:0] addr, input logic [15:0] data,
                                input logic [1:0] strb);
      int guard;
      reqValid = 1'b1;
      reqWrite = wr;
      reqAddr  = addr;
      reqData  = data;
      reqStrb  = strb;
      guard    = 0;
      while (!reqReady && guard < 20) begin
         tick();
         guard++;
      end
      if (!reqReady) begin
         checkOutput("reqTimeout", 32'd0, 32'd1);
      end
      tick();
      reqValid = 1'b0;
      reqWrite = 1'b0;
   endtask

   // Wait (bounded) for a response, check its data, then pop it.
   task automatic waitRsp(input string tag, input logic [15:0] expected);
      int guard;
      rspReady = 1'b1;
      guard    = 0;
      @(negedge clk);
      while (!rspValid && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      checkOutput({tag, "Valid"}, 32'(rspValid), 32'd1);
      checkOutput(tag, 32'(rspData), 32'(expected));
      tick();
   endtask

   initial begin
      rstN     = 1'b0;
      reqValid = 1'b0;
      reqWrite = 1'b0;
      reqAddr  = '0;
      reqData  = '0;
      reqStrb  = '0;
      rspReady = 1'b0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      checkOutput("rstReady", 32'(reqReady), 32'd1);
      checkOutput("rstRspValid", 32'(rspValid), 32'd0);
      checkOutput("rstRspData", 32'(rspData), 32'd0);
      checkOutput("rstMemEn", 32'(memEn), 32'd0);
      checkOutput("rstMemWr", 32'(memWr), 32'd0);
      rstN = 1'b1;
      tick();

      // Test 1: write then read back, check DELAY+1 latency
      applyStimulus(1'b1, 5'd5, 16'hA55A, 2'b11);
      rspReady = 1'b1;
      applyStimulus(1'b0, 5'd5, 16'h0000, 2'b00);
      @(negedge clk);
      checkOutput("t1Lat1", 32'(rspValid), 32'd0);
      @(negedge clk);
      checkOutput("t1Lat2", 32'(rspValid), 32'd0);
      @(negedge clk);
      checkOutput("t1Lat3", 32'(rspValid), 32'd1);
      checkOutput("t1Data", 32'(rspData), 32'hA55A);
      tick();
      @(negedge clk);
      checkOutput("t1Empty", 32'(rspValid), 32'd0);
      tick();

      // Test 2: byte mask honoured
      applyStimulus(1'b1, 5'd7, 16'hFFFF, 2'b11);
      reqValid = 1'b1;
      reqWrite = 1'b1;
      reqAddr  = 5'd7;
      reqData  = 16'h1200;
      reqStrb  = 2'b10;
      @(negedge clk);
      checkOutput("t2MemEn", 32'(memEn), 32'd1);
      checkOutput("t2MemWr", 32'(memWr), 32'b10);
      checkOutput("t2MemAddr", 32'(memAddr), 32'd7);
      checkOutput("t2MemDataIn", 32'(memDataIn), 32'h1200);
      tick();
      reqWrite = 1'b0;
      reqStrb  = 2'b11;
      @(negedge clk);
      checkOutput("t2ReadMemWr", 32'(memWr), 32'd0);
      checkOutput("t2ReadMemEn", 32'(memEn), 32'd1);
      tick();
      reqValid = 1'b0;
      waitRsp("t2Data", 16'h12FF);

      applyStimulus(1'b1, 5'd3, 16'h3C3C, 2'b11);
      applyStimulus(1'b1, 5'd9, 16'h9999, 2'b11);

      // Test 3: credits exhausted under back-pressure, then drain in order
      rspReady = 1'b0;
      reqValid = 1'b1;
      reqWrite = 1'b0;
      reqAddr  = 5'd5;
      tick();
      reqAddr = 5'd7;
      tick();
      reqAddr = 5'd3;
      @(negedge clk);
      checkOutput("t3ReadyBefore3", 32'(reqReady), 32'd1);
      tick();
      reqAddr = 5'd9;
      @(negedge clk);
      checkOutput("t3Stall", 32'(reqReady), 32'd0);
      tick();
      tick();
      tick();
      @(negedge clk);
      checkOutput("t3HeadValid", 32'(rspValid), 32'd1);
      checkOutput("t3Head", 32'(rspData), 32'hA55A);
      checkOutput("t3StillStalled", 32'(reqReady), 32'd0);
      tick();
      @(negedge clk);
      checkOutput("t3Hold", 32'(rspData), 32'hA55A);
      rspReady = 1'b1;
      checkOutput("t3NoSameCycleReady", 32'(reqReady), 32'd0);
      tick();
      @(negedge clk);
      checkOutput("t3ReadyAfterPop", 32'(reqReady), 32'd1);
      checkOutput("t3Second", 32'(rspData), 32'h12FF);
      tick();
      reqValid = 1'b0;
      @(negedge clk);
      checkOutput("t3Third", 32'(rspData), 32'h3C3C);
      tick();
      @(negedge clk);
      checkOutput("t3Gap", 32'(rspValid), 32'd0);
      tick();
      waitRsp("t3Fourth", 16'h9999);

      // Test 4: full FIFO drained with request held, one pop per cycle
      rspReady = 1'b0;
      reqValid = 1'b1;
      reqWrite = 1'b0;
      reqAddr  = 5'd3;
      tick();
      reqAddr = 5'd9;
      tick();
      reqAddr = 5'd5;
      tick();
      reqValid = 1'b0;
      tick();
      tick();
      tick();
      @(negedge clk);
      checkOutput("t4FullReady", 32'(reqReady), 32'd0);
      checkOutput("t4Head", 32'(rspData), 32'h3C3C);
      rspReady = 1'b1;
      reqValid = 1'b1;
      reqAddr  = 5'd7;
      tick();
      @(negedge clk);
      checkOutput("t4Ready1", 32'(reqReady), 32'd1);
      checkOutput("t4Data1", 32'(rspData), 32'h9999);
      tick();
      @(negedge clk);
      checkOutput("t4Ready2", 32'(reqReady), 32'd1);
      checkOutput("t4Data2", 32'(rspData), 32'hA55A);
      tick();
      @(negedge clk);
      checkOutput("t4Gap", 32'(rspValid), 32'd0);
      checkOutput("t4Ready3", 32'(reqReady), 32'd1);
      tick();
      reqValid = 1'b0;
      @(negedge clk);
      checkOutput("t4NewValid", 32'(rspValid), 32'd1);
      checkOutput("t4NewData", 32'(rspData), 32'h12FF);
      checkOutput("t4CreditsOut", 32'(reqReady), 32'd0);
      tick();
      @(negedge clk);
      checkOutput("t4NewValid2", 32'(rspValid), 32'd1);
      checkOutput("t4CreditBack", 32'(reqReady), 32'd1);
      tick();
      @(negedge clk);
      checkOutput("t4NewValid3", 32'(rspValid), 32'd1);
      checkOutput("t4NewData3", 32'(rspData), 32'h12FF);
      tick();
      @(negedge clk);
      checkOutput("t4Drained", 32'(rspValid), 32'd0);
      tick();

      // Test 5: reset while two reads are in flight
      rspReady = 1'b1;
      reqValid = 1'b1;
      reqWrite = 1'b0;
      reqAddr  = 5'd5;
      tick();
      reqAddr = 5'd7;
      tick();
      reqValid = 1'b0;
      rstN     = 1'b0;
      #2;
      checkOutput("t5RstValid", 32'(rspValid), 32'd0);
      checkOutput("t5RstReady", 32'(reqReady), 32'd1);
      checkOutput("t5RstData", 32'(rspData), 32'd0);
      @(negedge clk);
      rstN = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput($sformatf("t5NoStale%0d", i), 32'(rspValid), 32'd0);
      end
      checkOutput("t5ReadyAfter", 32'(reqReady), 32'd1);
      tick();
      applyStimulus(1'b0, 5'd3, 16'h0000, 2'b00);
      waitRsp("t5ReadAfter", 16'h3C3C);

`ifdef SIM_MEM_ADAPTER_STATS_EN
      // Test 6: statistics counters after a fresh reset
      rstN = 1'b0;
      @(negedge clk);
      checkOutput("t6RstRd", rdCnt, 32'd0);
      rstN = 1'b1;
      tick();
      rspReady = 1'b0;
      applyStimulus(1'b1, 5'd10, 16'h0A0A, 2'b11);
      applyStimulus(1'b1, 5'd11, 16'h0B0B, 2'b11);
      reqValid = 1'b1;
      reqWrite = 1'b0;
      reqAddr  = 5'd10;
      tick();
      reqAddr = 5'd11;
      tick();
      reqAddr = 5'd5;
      tick();
      for (int i = 0; i < 4; i++) begin
         tick();
      end
      reqValid = 1'b0;
      @(negedge clk);
      checkOutput("t6RdCnt", rdCnt, 32'd3);
      checkOutput("t6WrCnt", wrCnt, 32'd2);
      checkOutput("t6StallCnt", stallCnt, 32'd4);
      tick();
      waitRsp("t6Rsp1", 16'h0A0A);
      waitRsp("t6Rsp2", 16'h0B0B);
      waitRsp("t6Rsp3", 16'hA55A);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
